// File: rtl/pixel_arbiter.sv
// Four-column round-robin pixel arbiter feeding a small FIFO towards the VGA pixel port.
// Define PIXEL_CLIP_EN to drop (and count) granted pixels that fall outside H_RES x V_RES.
module pixel_arbiter #(
  parameter int DEPTH = 4,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [39:0] req_x,
  input  logic [35:0] req_y,
  input  logic [11:0] req_color,
  output logic [3:0]  gnt,
  input  logic        vga_ready,
  output logic        vga_write,
  output logic [9:0]  vga_x,
  output logic [8:0]  vga_y,
  output logic [2:0]  vga_color,
  output logic [4:0]  fifo_count,
  output logic [7:0]  drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]  DEPTH_C = 5'(DEPTH);
  localparam logic [10:0] H_LIM   = 11'(H_RES);
  localparam logic [9:0]  V_LIM   = 10'(V_RES);

  logic [1:0]    rr_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;

  logic [9:0] mem_x     [DEPTH];
  logic [8:0] mem_y     [DEPTH];
  logic [2:0] mem_color [DEPTH];

  logic [9:0] col_x     [4];
  logic [8:0] col_y     [4];
  logic [2:0] col_color [4];

  logic [1:0] gnt_idx;
  logic [1:0] cand;
  logic       gnt_any;
  logic [9:0] sel_x;
  logic [8:0] sel_y;
  logic [2:0] sel_color;
  logic       out_of_range;
  logic       push;
  logic       pop;

  for (genvar i = 0; i < 4; i++) begin : g_cols
    assign col_x[i]     = req_x[10*i +: 10];
    assign col_y[i]     = req_y[9*i +: 9];
    assign col_color[i] = req_color[3*i +: 3];
  end

  // Search starts at rr_ptr; a full FIFO blocks grants even if a pop happens this cycle.
  always_comb begin
    gnt     = 4'b0000;
    gnt_idx = rr_ptr;
    gnt_any = 1'b0;
    cand    = rr_ptr;
    if (!reset && (req != 4'b0000) && (count < DEPTH_C)) begin
      for (int k = 0; k < 4; k++) begin
        cand = rr_ptr + 2'(k);
        if (!gnt_any && req[cand]) begin
          gnt_any      = 1'b1;
          gnt_idx      = cand;
          gnt[cand]    = 1'b1;
        end
      end
    end
  end

  assign sel_x        = col_x[gnt_idx];
  assign sel_y        = col_y[gnt_idx];
  assign sel_color    = col_color[gnt_idx];
  assign out_of_range = ({1'b0, sel_x} >= H_LIM) || ({1'b0, sel_y} >= V_LIM);

`ifdef PIXEL_CLIP_EN
  assign push = gnt_any && !out_of_range;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      drop_count <= 8'd0;
    end else if (gnt_any && out_of_range && (drop_count != 8'hFF)) begin
      drop_count <= drop_count + 8'd1;
    end
  end
`else
  logic unused_clip;
  assign unused_clip = out_of_range;
  assign push        = gnt_any;
  assign drop_count  = 8'd0;
`endif

  assign vga_write = (count != 5'd0);
  assign pop       = vga_write && vga_ready;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rr_ptr <= 2'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (gnt_any) rr_ptr <= gnt_idx + 2'd1;
      if (push)    wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_x[wr_ptr]     <= sel_x;
      mem_y[wr_ptr]     <= sel_y;
      mem_color[wr_ptr] <= sel_color;
    end
  end

  assign vga_x      = vga_write ? mem_x[rd_ptr]     : 10'd0;
  assign vga_y      = vga_write ? mem_y[rd_ptr]     : 9'd0;
  assign vga_color  = vga_write ? mem_color[rd_ptr] : 3'd0;
  assign fifo_count = count;

endmodule

// File: tb/tb_pixel_arbiter.sv
// Table-driven bench for pixel_arbiter: round-robin order, FIFO fill/drain, full stall, reset flush,
// plus a hand-written clipping sequence whose expectations follow PIXEL_CLIP_EN.
module tb_pixel_arbiter;

  logic        CLOCK_50;
  logic        reset;
  logic [3:0]  req;
  logic [39:0] req_x;
  logic [35:0] req_y;
  logic [11:0] req_color;
  logic [3:0]  gnt;
  logic        vga_ready;
  logic        vga_write;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic [2:0]  vga_color;
  logic [4:0]  fifo_count;
  logic [7:0]  drop_count;

  int testsRun;
  int testsFailed;

  int colX [4];
  int colY [4];
  int colC [4];

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       ready;
    logic [3:0] gnt;
    int         count;
    int         head;
  } vec_t;

  vec_t vq[$];

  pixel_arbiter #(.DEPTH(4), .H_RES(640), .V_RES(480)) dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_color  (req_color),
    .gnt        (gnt),
    .vga_ready  (vga_ready),
    .vga_write  (vga_write),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_color  (vga_color),
    .fifo_count (fifo_count),
    .drop_count (drop_count)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic addVec(input logic r, input logic [3:0] rq, input logic rdy,
                        input logic [3:0] g, input int c, input int h);
    vec_t v;
    v.rst = r; v.req = rq; v.ready = rdy; v.gnt = g; v.count = c; v.head = h;
    vq.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic rdy);
    reset     = r;
    req       = rq;
    vga_ready = rdy;
    for (int i = 0; i < 4; i++) begin
      req_x[10*i +: 10]    = 10'(colX[i]);
      req_y[9*i +: 9]      = 9'(colY[i]);
      req_color[3*i +: 3]  = 3'(colC[i]);
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Head column -1 means the FIFO is expected empty, so every vga_* field reads 0.
  task automatic checkHead(input string tag, input int col);
    checkOutput({tag, ".vga_write"}, int'(vga_write), (col >= 0) ? 1 : 0);
    checkOutput({tag, ".vga_x"},     int'(vga_x),     (col >= 0) ? colX[col] : 0);
    checkOutput({tag, ".vga_y"},     int'(vga_y),     (col >= 0) ? colY[col] : 0);
    checkOutput({tag, ".vga_color"}, int'(vga_color), (col >= 0) ? colC[col] : 0);
  endtask

  task automatic nextEdge();
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    colX = '{10, 30, 100, 200};
    colY = '{20, 40, 50, 300};
    colC = '{1, 2, 7, 4};

    // rst, req, ready, expected gnt, expected count, expected head column
    addVec(1'b1, 4'b1111, 1'b1, 4'b0000, 0, -1);
    addVec(1'b0, 4'b1111, 1'b1, 4'b0001, 0, -1);
    addVec(1'b0, 4'b1111, 1'b1, 4'b0010, 1,  0);
    addVec(1'b0, 4'b1111, 1'b1, 4'b0100, 1,  1);
    addVec(1'b0, 4'b1111, 1'b1, 4'b1000, 1,  2);
    addVec(1'b0, 4'b1111, 1'b1, 4'b0001, 1,  3);
    addVec(1'b0, 4'b0000, 1'b1, 4'b0000, 1,  0);
    addVec(1'b0, 4'b0000, 1'b0, 4'b0000, 0, -1);
    addVec(1'b0, 4'b0100, 1'b0, 4'b0100, 0, -1);
    addVec(1'b0, 4'b0100, 1'b0, 4'b0100, 1,  2);
    addVec(1'b0, 4'b0100, 1'b0, 4'b0100, 2,  2);
    addVec(1'b0, 4'b0100, 1'b0, 4'b0100, 3,  2);
    addVec(1'b0, 4'b0100, 1'b0, 4'b0000, 4,  2);
    addVec(1'b0, 4'b0000, 1'b1, 4'b0000, 4,  2);
    addVec(1'b0, 4'b0000, 1'b1, 4'b0000, 3,  2);
    addVec(1'b0, 4'b0000, 1'b1, 4'b0000, 2,  2);
    addVec(1'b0, 4'b0000, 1'b1, 4'b0000, 1,  2);
    addVec(1'b0, 4'b0000, 1'b0, 4'b0000, 0, -1);
    addVec(1'b0, 4'b0001, 1'b0, 4'b0001, 0, -1);
    addVec(1'b0, 4'b0001, 1'b0, 4'b0001, 1,  0);
    addVec(1'b0, 4'b0001, 1'b0, 4'b0001, 2,  0);
    addVec(1'b0, 4'b0001, 1'b0, 4'b0001, 3,  0);
    addVec(1'b0, 4'b0001, 1'b1, 4'b0000, 4,  0);
    addVec(1'b0, 4'b0001, 1'b1, 4'b0001, 3,  0);
    addVec(1'b0, 4'b0000, 1'b1, 4'b0000, 3,  0);
    addVec(1'b0, 4'b1000, 1'b0, 4'b1000, 2,  0);
    addVec(1'b1, 4'b1111, 1'b1, 4'b0000, 3,  0);
    addVec(1'b0, 4'b1111, 1'b1, 4'b0001, 0, -1);
    addVec(1'b0, 4'b0010, 1'b0, 4'b0010, 1,  0);
    addVec(1'b0, 4'b0000, 1'b1, 4'b0000, 2,  0);
    addVec(1'b0, 4'b0000, 1'b1, 4'b0000, 1,  1);
    addVec(1'b0, 4'b0000, 1'b0, 4'b0000, 0, -1);

    applyStimulus(1'b1, 4'b0000, 1'b0);
    nextEdge();

    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      applyStimulus(vq[i].rst, vq[i].req, vq[i].ready);
      #4;
      checkOutput({tag, ".gnt"},        int'(gnt),        int'(vq[i].gnt));
      checkOutput({tag, ".fifo_count"}, int'(fifo_count), vq[i].count);
      checkOutput({tag, ".drop_count"}, int'(drop_count), 0);
      checkHead(tag, vq[i].head);
      nextEdge();
    end

    // Column 1 now points just off the right edge; round-robin pointer sits at column 2.
    colX[1] = 640; colY[1] = 10; colC[1] = 5;
    applyStimulus(1'b0, 4'b0010, 1'b0);
    #4;
    checkOutput("clip.gnt", int'(gnt), 4'b0010);
    nextEdge();
`ifdef PIXEL_CLIP_EN
    checkOutput("clip.count", int'(fifo_count), 0);
    checkOutput("clip.drop1", int'(drop_count), 1);
    checkHead("clip", -1);
    for (int n = 0; n < 299; n++) begin
      checkOutput($sformatf("clip.gnt%0d", n), int'(gnt), 4'b0010);
      nextEdge();
    end
    checkOutput("clip.drop_sat", int'(drop_count), 255);
    checkOutput("clip.count_sat", int'(fifo_count), 0);
    colX[1] = 639; colY[1] = 479;
    applyStimulus(1'b0, 4'b0010, 1'b0);
    nextEdge();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    #4;
    checkOutput("edge.count", int'(fifo_count), 1);
    checkOutput("edge.drop", int'(drop_count), 255);
    checkHead("edge", 1);
`else
    applyStimulus(1'b0, 4'b0000, 1'b0);
    #4;
    checkOutput("noclip.count", int'(fifo_count), 1);
    checkOutput("noclip.drop", int'(drop_count), 0);
    checkHead("noclip", 1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pixel_arbiter.md
PIXEL_ARBITER -- requirements
Module: pixel_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, pixel FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter H_RES, default 640, horizontal pixel limit used by clipping.
REQ-003 Parameter V_RES, default 480, vertical pixel limit used by clipping.
REQ-004 Port CLOCK_50  in  1  system clock; all state SHALL update on its rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port req  in  4  per-column pixel write request; bit i belongs to column i.
REQ-007 Port req_x  in  40  column i x coordinate in bits [10i+9:10i].
REQ-008 Port req_y  in  36  column i y coordinate in bits [9i+8:9i].
REQ-009 Port req_color  in  12  column i 3-bit colour in bits [3i+2:3i].
REQ-010 Port gnt  out  4  one-hot combinational grant; column i advances its pixel on an edge where req[i] and gnt[i] are both high.
REQ-011 Port vga_ready  in  1  downstream pixel port accepts the presented pixel this cycle.
REQ-012 Port vga_write  out  1  FIFO head valid.
REQ-013 Port vga_x / vga_y / vga_color  out  10 / 9 / 3  FIFO head pixel.
REQ-014 Port fifo_count  out  5  current FIFO occupancy, 0..DEPTH.
REQ-015 Port drop_count  out  8  clipped-pixel counter.

Function
REQ-016 Arbitration SHALL be round-robin: highest priority is requester ptr, then ptr+1, ptr+2, ptr+3 (mod 4).
REQ-017 gnt SHALL be nonzero only when req != 0 and fifo_count < DEPTH; at most one bit SHALL be set.
REQ-018 No full-FIFO bypass: with fifo_count == DEPTH, gnt SHALL be 0 even if a pop occurs that cycle.
REQ-019 On a grant to column i, ptr SHALL become (i+1) mod 4 at the next edge; with no grant ptr SHALL hold.
REQ-020 The granted column's x, y, colour SHALL be written to the FIFO tail at the grant edge (subject to REQ-032).
REQ-021 vga_write SHALL equal (fifo_count != 0); vga_x/vga_y/vga_color SHALL present the head entry, and SHALL be 0 when empty.
REQ-022 A pop SHALL occur at an edge where vga_write and vga_ready are high.
REQ-023 Latency: a pixel granted at edge N into an empty FIFO SHALL appear on vga_* in the cycle after edge N.
REQ-024 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-025 Pointer arithmetic SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH nor underflow.
REQ-026 A requester holding req high SHALL be served within 4 grants (starvation-free).
REQ-027 gnt SHALL be 0 in any cycle where reset is high.

Reset
REQ-028 On reset: ptr = 0, FIFO read/write pointers = 0, fifo_count = 0, drop_count = 0.
REQ-029 Outputs after reset edge: vga_write = 0, vga_x = 0, vga_y = 0, vga_color = 0, gnt = 0 while reset high.
REQ-030 Reset mid-operation SHALL discard all queued pixels; no pop SHALL be counted at the reset edge.

Configuration
REQ-031 Macro PIXEL_CLIP_EN SHALL select coordinate clipping.
REQ-032 With PIXEL_CLIP_EN defined: a granted pixel with x >= H_RES or y >= V_RES SHALL still be granted but SHALL NOT be pushed; drop_count SHALL increment, saturating at 255.
REQ-033 Without PIXEL_CLIP_EN: all granted pixels SHALL be pushed unchanged; drop_count SHALL be tied to 0.

Verification
REQ-034 Reset, req = 4'b1111 constant, vga_ready = 1 -> gnt sequence 0001, 0010, 0100, 1000, 0001; each pixel on vga_* one cycle after its grant.
REQ-035 vga_ready = 0, req[2] = 1 with x = 100, y = 50, colour = 7 -> 4 grants, fifo_count = 4, gnt = 0 thereafter; raise vga_ready -> four pixels drain in order.
REQ-036 FIFO full, vga_ready = 1, req[0] = 1 -> first cycle gnt = 0 with pop (count 3); next cycle grant with push and pop (count stays 3).
REQ-037 PIXEL_CLIP_EN defined, column 1 requests x = 640, y = 10 -> gnt[1] = 1, fifo_count unchanged, drop_count = 1; 300 such pixels -> drop_count = 255.
REQ-038 Three pixels queued, reset asserted one cycle -> fifo_count = 0, vga_write = 0, ptr = 0 (next grant with req = 1111 is 0001).
